dram_pattern_tester: RTL

DRAM_PATTERN_TESTER -- requirements
Module: dram_pattern_tester

---
 rtl/dram_pattern_tester.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/dram_pattern_tester.sv
// Self-contained DRAM pattern tester: writes a pattern over a word range through a
// single-master bus, reads it back, counts mismatches and optionally loops patterns.
module dram_pattern_tester #(
   parameter int WORD_SIZE      = 256,
   parameter int NUM_WORDS      = 16,
   parameter int BASE_IDX       = 0,
   parameter int ADDR_SHIFT     = 7,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                 sys_clk_100mhz,
   input  logic                 rst_n,
   input  logic                 initialized,
   input  logic                 start,
   input  logic [1:0]           pattern_sel,
   input  logic                 loop_en,
   output logic                 cyc_o,
   output logic                 stb_o,
   output logic                 we_o,
   output logic [31:0]          addr_o,
   output logic [WORD_SIZE-1:0] wdata_o,
   input  logic [WORD_SIZE-1:0] rdata_i,
   input  logic                 ack_i,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic                 fail,
   output logic                 timeout,
   output logic [15:0]          err_count,
   output logic [31:0]          first_err_idx,
   output logic [15:0]          pass_count,
   output logic [7:0]           led
);

   localparam int LANES = WORD_SIZE / 32;
   localparam logic [31:0] LAST_IDX  = 32'(NUM_WORDS - 1);
   localparam logic [31:0] LAST_TICK = 32'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE, WAIT_INIT, WRITE, WAIT_WRITE, READ, WAIT_READ, CHECK, DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [31:0]            idx_q, idx_d;
   logic [1:0]             pattern_q, pattern_d;
   logic [15:0]            err_q, err_d;
   logic [31:0]            ferr_q, ferr_d;
   logic [15:0]            pcnt_q, pcnt_d;
   logic                   tout_q, tout_d;
   logic [31:0]            tcnt_q, tcnt_d;
   logic [WORD_SIZE-1:0]   rdata_q, rdata_d;

   logic [31:0]            widx;
   logic [WORD_SIZE-1:0]   exp_word;
   logic                   bus_act, wr_act;

   function automatic logic [31:0] lane_f(input logic [1:0] p, input logic [31:0] w);
      logic [31:0] r;
      case (p)
         2'd0:    r = 32'hA5A5_A5A5;
         2'd1:    r = w[0] ? 32'h5A5A_5A5A : 32'hA5A5_A5A5;
         2'd2:    r = w;
         default: r = ~w;
      endcase
      return r;
   endfunction

   assign widx     = 32'(BASE_IDX) + idx_q;
   assign exp_word = {LANES{lane_f(pattern_q, widx)}};

   always_ff @(posedge sys_clk_100mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         pattern_q <= '0;
         err_q     <= '0;
         ferr_q    <= '0;
         pcnt_q    <= '0;
         tout_q    <= 1'b0;
         tcnt_q    <= '0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         pattern_q <= pattern_d;
         err_q     <= err_d;
         ferr_q    <= ferr_d;
         pcnt_q    <= pcnt_d;
         tout_q    <= tout_d;
         tcnt_q    <= tcnt_d;
         rdata_q   <= rdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pattern_d = pattern_q;
      err_d     = err_q;
      ferr_d    = ferr_q;
      pcnt_d    = pcnt_q;
      tout_d    = tout_q;
      tcnt_d    = tcnt_q;
      rdata_d   = rdata_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               err_d     = '0;
               ferr_d    = '0;
               pcnt_d    = '0;
               tout_d    = 1'b0;
               idx_d     = '0;
               pattern_d = pattern_sel;
               state_d   = WAIT_INIT;
            end
         end
         WAIT_INIT: begin
            if (initialized) begin
               idx_d   = '0;
               state_d = WRITE;
            end
         end
         WRITE: begin
            tcnt_d  = '0;
            state_d = WAIT_WRITE;
         end
         WAIT_WRITE: begin
            if (ack_i) begin
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = READ;
               end else begin
                  idx_d   = idx_q + 32'd1;
                  state_d = WRITE;
               end
            end else if (tcnt_q == LAST_TICK) begin
               tout_d  = 1'b1;
               state_d = DONE;
            end else begin
               tcnt_d = tcnt_q + 32'd1;
            end
         end
         READ: begin
            tcnt_d  = '0;
            state_d = WAIT_READ;
         end
         WAIT_READ: begin
            if (ack_i) begin
               rdata_d = rdata_i;
               state_d = CHECK;
            end else if (tcnt_q == LAST_TICK) begin
               tout_d  = 1'b1;
               state_d = DONE;
            end else begin
               tcnt_d = tcnt_q + 32'd1;
            end
         end
         CHECK: begin
            // err_q is cleared per run and saturates, so zero means no earlier mismatch
            if (rdata_q != exp_word) begin
               if (err_q == '0) ferr_d = widx;
               if (err_q != '1) err_d = err_q + 16'd1;
            end
            if (idx_q == LAST_IDX) begin
               if (pcnt_q != '1) pcnt_d = pcnt_q + 16'd1;
               if (loop_en) begin
                  pattern_d = pattern_q + 2'd1;
                  idx_d     = '0;
                  state_d   = WRITE;
               end else begin
                  state_d = DONE;
               end
            end else begin
               idx_d   = idx_q + 32'd1;
               state_d = READ;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Bus outputs decode from state so reset clears them without waiting for an edge
   assign bus_act = (state_q == WRITE) || (state_q == WAIT_WRITE) ||
                    (state_q == READ)  || (state_q == WAIT_READ);
   assign wr_act  = (state_q == WRITE) || (state_q == WAIT_WRITE);

   assign cyc_o   = bus_act;
   assign stb_o   = bus_act;
   assign we_o    = wr_act;
   assign addr_o  = bus_act ? (widx << ADDR_SHIFT) : '0;
   assign wdata_o = wr_act ? exp_word : '0;

   assign busy          = (state_q != IDLE) && (state_q != DONE);
   assign done          = (state_q == DONE);
   assign pass          = done && (err_q == '0) && !tout_q;
   assign fail          = done && !pass;
   assign timeout       = tout_q;
   assign err_count     = err_q;
   assign first_err_idx = ferr_q;
   assign pass_count    = pcnt_q;
   assign led           = {pass, fail, timeout, loop_en, pattern_q, busy, initialized};

endmodule
